dm_frame_ctrl: RTL

DM_FRAME_CTRL -- requirements
Module: dm_frame_ctrl

---
 rtl/dm_frame_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/dm_frame_ctrl.sv
// rtl/dm_frame_ctrl.sv - double-buffered image arbiter for a dot-matrix scanner
// Two requesters load a back buffer; it swaps to the display only on a qualifying end-of-frame.
module dm_frame_ctrl #(
    parameter int MIN_FRAMES = 4
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_fDone,
    input  logic        i_Req0,
    input  logic [63:0] i_Data0,
    input  logic        i_Req1,
    input  logic [63:0] i_Data1,
    output logic        o_Ack0,
    output logic        o_Ack1,
    output logic [63:0] o_Data,
    output logic        o_Src,
    output logic        o_Busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    localparam logic [3:0] CNT_MAX = 4'(MIN_FRAMES - 1);

    state_t      state_q, state_d;
    logic [63:0] back_q, back_d;
    logic        back_src_q, back_src_d;
    logic        last_q, last_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] data_q, data_d;
    logic        src_q, src_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;

    logic        grant_valid;
    logic        grant_idx;
    logic        swap;

    // On a tie the requester not granted last time wins; a lone request always wins.
    assign grant_valid = i_Req0 | i_Req1;
    assign grant_idx   = (i_Req0 & i_Req1) ? ~last_q : i_Req1;
    assign swap        = (state_q == ST_PEND) && i_fDone && (cnt_q == CNT_MAX);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant_valid) state_d = ST_PEND;
            ST_PEND: if (swap)        state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        back_d     = back_q;
        back_src_d = back_src_q;
        last_d     = last_q;
        data_d     = data_q;
        src_d      = src_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        cnt_d      = cnt_q;

        if (swap) begin
            cnt_d = 4'd0;
        end else if (i_fDone && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 4'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    back_d     = grant_idx ? i_Data1 : i_Data0;
                    back_src_d = grant_idx;
                    last_d     = grant_idx;
                    ack0_d     = ~grant_idx;
                    ack1_d     = grant_idx;
                end
            end
            ST_PEND: begin
                // The display only changes on the end-of-frame edge, so no frame tears.
                if (swap) begin
                    data_d = back_q;
                    src_d  = back_src_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            back_q     <= 64'd0;
            back_src_q <= 1'b0;
            last_q     <= 1'b1;
            cnt_q      <= CNT_MAX;
            data_q     <= 64'd0;
            src_q      <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
        end else begin
            back_q     <= back_d;
            back_src_q <= back_src_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            src_q      <= src_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
        end
    end

    assign o_Ack0 = ack0_q;
    assign o_Ack1 = ack1_q;
    assign o_Data = data_q;
    assign o_Src  = src_q;
    assign o_Busy = (state_q == ST_PEND);

endmodule
